muldiv_iter: RTL and testbench
==============================

# muldiv_iter

Parametrised multiply/divide unit for the CPU's HI/LO path. It accepts one operation per `start` pulse and computes the following:
- signed or unsigned multiply, with a configurable fixed latency;
- signed or unsigned divide, using a native radix-2 restoring divider with no vendor IP.

It exposes `busy`/`done` to the execute stage for stalling and holds the last result until a new operation completes. It supports synchronous `cancel` for exception flush.

## Interface

**Parameters**
- `WIDTH`, default 32: operand width. Must be ≥ 2.
- `MUL_CYCLES`, default 1: multiply latency in clock edges. Must be ≥ 1.

**Ports**
- `aclk` in, 1: clock. Single clock domain.
- `aresetn` in, 1: reset, asynchronous, active-low.
- `start` in, 1: launch an operation. Sampled only when `busy`=0.
- `op` in, 2: 00 signed mul, 01 unsigned mul, 10 unsigned div, 11 signed div.
- `a` in, WIDTH: multiplicand or dividend. Sampled with `start`.
- `b` in, WIDTH: multiplier or divisor. Sampled with `start`.
- `cancel` in, 1: abort the operation in flight.
- `busy` out, 1: an operation is in flight.
- `done` out, 1: one-cycle pulse marking the cycle in which `result` becomes new.
- `result` out, 2*WIDTH: product {hi, lo}, or {remainder, quotient} for divide.

## Operation

**States:** IDLE, MUL, DIV, FIX. `busy` = (state != IDLE).

**IDLE**
- `start`=1 and `cancel`=0: latch operands and `op`, and zero the iteration counter.
- `op[1]`=0 goes to MUL; `op[1]`=1 goes to DIV.
- Signed modes capture magnitudes plus sign flags: quotient sign = a[W-1]^b[W-1]; remainder sign = a[W-1].

**MUL**
- Counter runs for MUL_CYCLES edges.
- On the last edge: write the product to `result`, pulse `done`, return to IDLE.
- Signed mode gives the 2W-bit two's-complement product; unsigned mode gives the 2W-bit unsigned product.

**DIV**
- One quotient bit per edge for WIDTH edges: shift the partial remainder left, trial-subtract the divisor magnitude, keep the difference if it is non-negative, and shift in the quotient bit.
- After WIDTH edges, go to FIX.

**FIX** (one edge)
- Apply sign corrections, write `result`, pulse `done`, go to IDLE.

**Divide edge cases**
- Divide by zero: quotient = all ones, remainder = `a` (the original dividend, unmodified). Latency is unchanged.
- Signed MIN / -1: quotient = MIN, remainder = 0. This falls out naturally from the magnitude algorithm.

**Control rules**
- `start` while `busy`=1 is ignored and does not queue.
- `cancel`=1 while busy: return to IDLE on the next edge, `result` is unchanged, no `done`.
- `cancel` and `start` in the same IDLE cycle: cancel wins and nothing launches.
- `cancel` in IDLE has no effect.
- `result` holds its value indefinitely between `done` pulses. Operand inputs may change freely after the `start` edge.

## Timing

- **Reset** (asynchronous, `aresetn`=0): state IDLE, `busy`=0, `done`=0, `result`=0, counter=0. Reset mid-operation discards the operation.
- **`start` edge:** `start` is sampled at edge k while `busy`=0.
- **Multiply:** `busy`=1 after edge k. At edge k+MUL_CYCLES, `result` updates, `done`=1 for one cycle and `busy`=0.
- **Divide:** `busy`=1 after edge k. Iterations occur on edges k+1 … k+WIDTH. FIX occurs at edge k+WIDTH+1, where `result` updates, `done`=1 and `busy`=0. Total latency is WIDTH+1 edges, data-independent.
- **Back-to-back:** a new `start` may be sampled in the same cycle `done`=1, since `busy` is already 0. The next operation's `done` never overlaps the previous one's.
- **Outputs:** `done` and `busy` are registered (no combinational path from inputs).

## Test plan

1. **Reset:** assert `aresetn`=0 mid-divide → `busy`=0, `done`=0, `result`=0 immediately. Release, then IDLE.
2. **Multiply** (WIDTH=32, MUL_CYCLES=1):
   - signed mul a=0xFFFFFFFE (-2), b=3 → `result`=0xFFFFFFFF_FFFFFFFA, `done` at edge k+1;
   - unsigned mul of the same operands → `result`=0x00000002_FFFFFFFA.
3. **Signed divide:**
   - a=-7, b=2 → quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1), `done` exactly at edge k+33, `busy` high for 33 cycles;
   - unsigned divide a=100, b=7 → {2, 14}.
4. **Boundaries:**
   - unsigned divide a=5, b=0 → quotient 0xFFFFFFFF, remainder 5;
   - signed divide a=0x80000000, b=-1 → quotient 0x80000000, remainder 0.
5. **Cancel and ignored start:**
   - start divide, assert `cancel` at iteration 10 → `busy`=0 next edge, no `done`, `result` keeps the prior value;
   - `start`+`cancel` together in IDLE → nothing launches;
   - `start` pulses during `busy` → ignored.
6. **Back-to-back** (MUL_CYCLES=3): a multiply is followed by a divide launched in the `done` cycle → two `done` pulses exactly 3 and 33 edges apart, each with the correct result. Randomised operands are checked against a reference model for WIDTH=8 and WIDTH=32.

Source files
------------

// File: rtl/muldiv_iter_if.sv
// Handshake/data bundle between the execute stage and the HI/LO multiply/divide unit.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic [1:0]           op;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 cancel;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   result;

    modport master (output start, op, a, b, cancel, input busy, done, result);
    modport slave  (input start, op, a, b, cancel, output busy, done, result);
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide for the HI/LO path: fixed-latency multiply, radix-2 restoring
// divide on magnitudes with a final sign-fix edge.
module muldiv_iter #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 1
) (
    input  logic         aclk,
    input  logic         aresetn,
    muldiv_iter_if.slave bus
);
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    typedef struct packed {
        logic             sgn;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t               state;
    req_t                 req;
    logic                 q_neg;
    logic                 r_neg;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     rem;
    logic [WIDTH-1:0]     quo;
    logic [WIDTH-1:0]     dvs;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   result_q;

    // op 00 and 11 are the signed flavours
    logic                 launch_sgn;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    assign launch_sgn = ~(bus.op[1] ^ bus.op[0]);
    assign mag_a = (launch_sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign mag_b = (launch_sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Sign- or zero-extending to 2W lets one multiplier serve both modes.
    logic [2*WIDTH-1:0]   ext_a;
    logic [2*WIDTH-1:0]   ext_b;
    logic [2*WIDTH-1:0]   product;
    assign ext_a   = {{WIDTH{req.sgn & req.a[WIDTH-1]}}, req.a};
    assign ext_b   = {{WIDTH{req.sgn & req.b[WIDTH-1]}}, req.b};
    assign product = ext_a * ext_b;

    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       diff;
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    // Divide-by-zero bypasses the sign fix so the remainder is the raw dividend.
    logic                 div_zero;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    assign div_zero = (req.b == '0);
    assign q_fix    = div_zero ? '1    : (q_neg ? -quo : quo);
    assign r_fix    = div_zero ? req.a : (r_neg ? -rem : rem);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state    <= IDLE;
            req      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        req.sgn <= launch_sgn;
                        req.a   <= bus.a;
                        req.b   <= bus.b;
                        q_neg   <= launch_sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        r_neg   <= launch_sgn & bus.a[WIDTH-1];
                        cnt     <= '0;
                        rem     <= '0;
                        quo     <= mag_a;
                        dvs     <= mag_b;
                        busy_q  <= 1'b1;
                        state   <= bus.op[1] ? DIV : MUL;
                    end
                end
                MUL: begin
                    if (bus.cancel) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt == MUL_LAST) begin
                        result_q <= product;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    if (bus.cancel) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        // quo shifts the dividend out and the quotient bits in
                        if (!diff[WIDTH]) begin
                            rem <= diff[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[WIDTH-1:0];
                            quo <= {quo[WIDTH-2:0], 1'b0};
                        end
                        if (cnt == DIV_LAST) state <= FIX;
                        else                 cnt   <= cnt + 1'b1;
                    end
                end
                FIX: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                    if (!bus.cancel) begin
                        result_q <= {r_fix, q_fix};
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard bench: directed cases on a 32-bit/1-cycle unit, back-to-back random runs on
// a 32-bit/3-cycle and an 8-bit/2-cycle unit, all against a longint reference model.
module tb_muldiv_iter;
    logic aclk = 1'b0;
    logic aresetn;
    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int nd1   = 0;
    logic [63:0] q1[$];
    logic [63:0] q3[$];
    logic [63:0] q8[$];
    logic [63:0] last1;

    muldiv_iter_if #(.WIDTH(32)) m1();
    muldiv_iter_if #(.WIDTH(32)) m3();
    muldiv_iter_if #(.WIDTH(8))  m8();

    muldiv_iter #(.WIDTH(32), .MUL_CYCLES(1)) u_dut1 (.aclk(aclk), .aresetn(aresetn), .bus(m1));
    muldiv_iter #(.WIDTH(32), .MUL_CYCLES(3)) u_dut3 (.aclk(aclk), .aresetn(aresetn), .bus(m3));
    muldiv_iter #(.WIDTH(8),  .MUL_CYCLES(2)) u_dut8 (.aclk(aclk), .aresetn(aresetn), .bus(m8));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_model(input int w, input logic [1:0] op,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [63:0] msk, msk2, ua, ub, q, r;
        longint sa, sb;
        msk  = (64'd1 << w) - 64'd1;
        msk2 = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
        ua = {32'd0, a} & msk;
        ub = {32'd0, b} & msk;
        sa = longint'(ua);
        sb = longint'(ub);
        if (ua[w-1]) sa -= longint'(msk) + 1;
        if (ub[w-1]) sb -= longint'(msk) + 1;
        case (op)
            2'b00:   return 64'(sa * sb) & msk2;
            2'b01:   return (ua * ub) & msk2;
            default: begin
                if (ub == 0)    begin q = msk;         r = ua;          end
                else if (op[0]) begin q = 64'(sa / sb); r = 64'(sa % sb); end
                else            begin q = ua / ub;     r = ua % ub;     end
                return ((r & msk) << w) | (q & msk);
            end
        endcase
    endfunction

    function automatic logic [31:0] rnd_opnd(input int w);
        logic [31:0] msk;
        msk = (w == 32) ? '1 : ((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 6))
            0:       return '0;
            1:       return 32'd1 << (w - 1);
            2:       return msk;
            3:       return 32'd1;
            default: return $urandom & msk;
        endcase
    endfunction

    // scoreboard monitors
    always @(negedge aclk) begin
        if (aresetn && m1.done) begin
            nd1++;
            if (q1.size() != 0) chk("m1_result", m1.result, q1.pop_front());
            else                chk("m1_spurious_done", 64'(m1.done), 64'd0);
        end
        if (aresetn && m3.done) begin
            if (q3.size() != 0) chk("m3_result", m3.result, q3.pop_front());
            else                chk("m3_spurious_done", 64'(m3.done), 64'd0);
        end
        if (aresetn && m8.done) begin
            if (q8.size() != 0) chk("m8_result", 64'(m8.result), q8.pop_front());
            else                chk("m8_spurious_done", 64'(m8.done), 64'd0);
        end
    end

    task automatic launch1(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int c0);
        m1.start = 1'b1; m1.op = op; m1.a = a; m1.b = b;
        c0 = cyc;
        @(negedge aclk);
        m1.start = 1'b0; m1.a = ~a; m1.b = ~b;
    endtask

    task automatic wait1(input int c0, output int lat, output int nb);
        lat = -1;
        nb  = 0;
        for (int t = 0; t < 200; t++) begin
            if (m1.busy) nb++;
            @(negedge aclk);
            if (m1.done) begin
                lat = cyc - c0 - 1;
                break;
            end
        end
    endtask

    task automatic run1(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
        int c0, lat, nb;
        q1.push_back(exp);
        last1 = exp;
        launch1(op, a, b, c0);
        wait1(c0, lat, nb);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_cycles"}, 64'(nb), 64'(exp_lat));
        @(negedge aclk);
        chk({tag, "_done_pulse"}, 64'(m1.done), 64'd0);
    endtask

    task automatic b2b32(input int n);
        logic [1:0] op;
        logic [31:0] a, b;
        int c0;
        bit got;
        @(negedge aclk);
        for (int i = 0; i < n; i++) begin
            op = (i == 0) ? 2'b01 : (i == 1) ? 2'b11 : 2'($urandom_range(0, 3));
            a = rnd_opnd(32);
            b = rnd_opnd(32);
            m3.start = 1'b1; m3.op = op; m3.a = a; m3.b = b;
            c0 = cyc;
            q3.push_back(ref_model(32, op, a, b));
            got = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge aclk);
                m3.start = 1'b0; m3.a = ~a; m3.b = ~b;
                if (m3.done) begin got = 1'b1; break; end
            end
            chk("m3_lat", got ? 64'(cyc - c0 - 1) : '1, op[1] ? 64'd33 : 64'd3);
            chk("m3_busy_at_done", 64'(m3.busy), 64'd0);
        end
        @(negedge aclk);
        chk("m3_done_pulse", 64'(m3.done), 64'd0);
    endtask

    task automatic b2b8(input int n);
        logic [1:0] op;
        logic [31:0] a, b;
        int c0;
        bit got;
        @(negedge aclk);
        for (int i = 0; i < n; i++) begin
            op = 2'($urandom_range(0, 3));
            a = rnd_opnd(8);
            b = rnd_opnd(8);
            m8.start = 1'b1; m8.op = op; m8.a = a[7:0]; m8.b = b[7:0];
            c0 = cyc;
            q8.push_back(ref_model(8, op, a, b));
            got = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge aclk);
                m8.start = 1'b0; m8.a = ~a[7:0]; m8.b = ~b[7:0];
                if (m8.done) begin got = 1'b1; break; end
            end
            chk("m8_lat", got ? 64'(cyc - c0 - 1) : '1, op[1] ? 64'd9 : 64'd2);
        end
    endtask

    initial begin
        int c0, lat, nb, nd_before;
        m1.start = 0; m1.op = 0; m1.a = 0; m1.b = 0; m1.cancel = 0;
        m3.start = 0; m3.op = 0; m3.a = 0; m3.b = 0; m3.cancel = 0;
        m8.start = 0; m8.op = 0; m8.a = 0; m8.b = 0; m8.cancel = 0;
        last1 = '0;
        aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        chk("reset_busy",   64'(m1.busy), 64'd0);
        chk("reset_done",   64'(m1.done), 64'd0);
        chk("reset_result", m1.result,    64'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        run1("smul",      2'b00, 32'hFFFF_FFFE, 32'd3,        64'hFFFF_FFFF_FFFF_FFFA, 1);
        run1("umul",      2'b01, 32'hFFFF_FFFE, 32'd3,        64'h0000_0002_FFFF_FFFA, 1);
        run1("sdiv",      2'b11, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 33);
        run1("udiv",      2'b10, 32'd100,       32'd7,        64'h0000_0002_0000_000E, 33);
        run1("udiv_zero", 2'b10, 32'd5,         32'd0,        64'h0000_0005_FFFF_FFFF, 33);
        run1("sdiv_ovf",  2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);

        // cancel at iteration 10
        nd_before = nd1;
        launch1(2'b10, 32'd1000, 32'd3, c0);
        repeat (9) @(negedge aclk);
        m1.cancel = 1'b1;
        @(negedge aclk);
        m1.cancel = 1'b0;
        chk("cancel_busy",   64'(m1.busy), 64'd0);
        chk("cancel_result", m1.result,    last1);
        repeat (40) @(negedge aclk);
        chk("cancel_no_done", 64'(nd1 - nd_before), 64'd0);

        // start and cancel together in IDLE
        m1.start = 1'b1; m1.cancel = 1'b1; m1.op = 2'b01; m1.a = 32'd9; m1.b = 32'd9;
        @(negedge aclk);
        m1.start = 1'b0; m1.cancel = 1'b0;
        chk("startcancel_busy", 64'(m1.busy), 64'd0);
        repeat (5) @(negedge aclk);
        chk("startcancel_no_done", 64'(nd1 - nd_before), 64'd0);
        chk("startcancel_result",  m1.result, last1);

        // starts while busy are dropped
        q1.push_back(64'h0000_0002_0000_000E);
        last1 = 64'h0000_0002_0000_000E;
        launch1(2'b10, 32'd100, 32'd7, c0);
        for (int i = 0; i < 5; i++) begin
            m1.start = 1'b1; m1.op = 2'b01; m1.a = $urandom; m1.b = $urandom;
            @(negedge aclk);
            m1.start = 1'b0;
            @(negedge aclk);
        end
        wait1(c0, lat, nb);
        chk("busy_start_lat", 64'(lat), 64'd33);
        repeat (5) @(negedge aclk);
        chk("busy_start_one_done", 64'(nd1 - nd_before), 64'd1);
        chk("busy_start_idle",     64'(m1.busy), 64'd0);

        // reset in the middle of a divide
        launch1(2'b11, 32'd12345, 32'd17, c0);
        repeat (5) @(negedge aclk);
        #1 aresetn = 1'b0;
        #1;
        chk("midreset_busy",   64'(m1.busy), 64'd0);
        chk("midreset_done",   64'(m1.done), 64'd0);
        chk("midreset_result", m1.result,    64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        repeat (2) @(negedge aclk);
        chk("postreset_idle", 64'(m1.busy), 64'd0);

        b2b32(20);
        b2b8(40);
        repeat (3) @(negedge aclk);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q3_drained", 64'(q3.size()), 64'd0);
        chk("q8_drained", 64'(q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
